uart_word_loader: RTL and testbench

Parametrised UART receive-and-assemble block that deserialises 8N1 bytes from a host, packs them into memory words of configurable width and byte order, and presents each completed word with an auto-incrementing address for instruction/data memory preloading. It sits between the board's `uart_rx` pin and the memory write port of the RISC-V core. It adds frame-error reporting, false-start rejection, a partial-word timeout and an address clear to the earlier fixed 32-bit loader.

---
 rtl/uart_word_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_word_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_loader.sv
// ---------------------------------------------------------------------------
// uart_word_loader
//   Receives 8N1 (or 8E1) UART bytes, packs WORD_BYTES of them into one memory
//   word in the selected byte order and presents each finished word with an
//   auto-incrementing address. Intended for preloading core memories.
//
//   Optional feature macro: UART_LOADER_PARITY_EN
//     defined   -> 11-bit frame with even parity, parity errors flagged
//     undefined -> 10-bit 8N1 frame, no parity logic
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   uart_rx      : serial input, idle high, asynchronous to clk
//   addr_clr     : synchronous clear of next address and byte counter
//   word_valid   : 1-cycle pulse, word_data/word_addr just updated
//   word_data    : assembled word, held until the next completion
//   word_addr    : address of word_data, held until the next completion
//   frame_err    : 1-cycle pulse on bad stop bit (or bad parity)
//   busy         : receive FSM is not idle
// ---------------------------------------------------------------------------
module uart_word_loader #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int WORD_BYTES   = 4,
    parameter int ADDR_W       = 16,
    parameter int ADDR_STEP    = 4,
    parameter int BIG_ENDIAN   = 0,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    uart_rx,
    input  logic                    addr_clr,
    output logic                    word_valid,
    output logic [8*WORD_BYTES-1:0] word_data,
    output logic [ADDR_W-1:0]       word_addr,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BCW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TCW  = $clog2(TLIM + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef UART_LOADER_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd5;
`endif

    logic                    rx_meta, rxs, rxs_prev;
    logic [2:0]              state;
    logic [CW-1:0]           cnt;
    logic [2:0]              bitn;
    logic [7:0]              shreg;
    logic [BCW-1:0]          bcnt;
    logic [ADDR_W-1:0]       addr;
    logic [8*WORD_BYTES-1:0] asm_q, next_asm;
    logic [TCW-1:0]          tcnt;

    logic tick, fall, stop_sample, accept, reject, last, timeout_hit, par_err;
    int   lane;

    // Two-flop synchroniser plus one delay stage for edge detection; all
    // reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= uart_rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign tick        = (cnt == '0);
    assign fall        = rxs_prev & ~rxs;
    assign stop_sample = (state == STOP) && tick;
    assign accept      = stop_sample && rxs && !par_err;
    assign reject      = stop_sample && !(rxs && !par_err);
    assign last        = (bcnt == BCW'(WORD_BYTES - 1));
    assign timeout_hit = (state == IDLE) && (bcnt != '0) && (tcnt == TCW'(TLIM - 1));
    assign busy        = (state != IDLE);

`ifdef UART_LOADER_PARITY_EN
    logic par_bit;
    // Even parity: data bits XOR parity bit must be zero.
    assign par_err = (^shreg) ^ par_bit;
`else
    assign par_err = 1'b0;
`endif

    // Receive FSM. The bit counter counts down and expires at zero, so a
    // load of N-1 means the next event is N cycles away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
`ifdef UART_LOADER_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        cnt   <= CW'(CLKS_PER_BIT / 2 - 1);
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rxs) begin
                            state <= DATA;
                            cnt   <= CW'(CLKS_PER_BIT - 1);
                            bitn  <= '0;
                        end else begin
                            state <= IDLE;   // glitch, not a start bit
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= {rxs, shreg[7:1]};   // LSB arrives first
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        bitn  <= bitn + 3'd1;
                        if (bitn == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`ifdef UART_LOADER_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_bit <= rxs;
                        cnt     <= CW'(CLKS_PER_BIT - 1);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (tick) state <= rxs ? IDLE : WAIT_HIGH;
                    else      cnt   <= cnt - CW'(1);
                end
                WAIT_HIGH: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Insert the incoming byte into its lane of the assembly register.
    always_comb begin
        next_asm = asm_q;
        lane     = (BIG_ENDIAN != 0) ? (WORD_BYTES - 1 - int'(bcnt)) : int'(bcnt);
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i == lane) next_asm[i*8 +: 8] = shreg;
        end
    end

    // Idle counter for discarding a stale partial word. Restarts on any
    // start edge and whenever no partial word is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if ((state == IDLE) && (bcnt != '0) && !fall && !timeout_hit)
            tcnt <= tcnt + TCW'(1);
        else
            tcnt <= '0;
    end

    // Word assembly, address and output registers. addr_clr is applied last
    // so it overrides both the increment and the byte counter update, while
    // a coincident completion still reports the pre-clear address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt       <= '0;
            addr       <= '0;
            asm_q      <= '0;
            word_data  <= '0;
            word_addr  <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (accept) begin
                asm_q <= next_asm;
                if (last) begin
                    word_data  <= next_asm;
                    word_addr  <= addr;
                    word_valid <= 1'b1;
                    addr       <= addr + ADDR_W'(ADDR_STEP);
                    bcnt       <= '0;
                end else begin
                    bcnt <= bcnt + BCW'(1);
                end
            end
            if (reject) begin
                frame_err <= 1'b1;
                bcnt      <= '0;
            end
            if (timeout_hit) bcnt <= '0;
            if (addr_clr) begin
                addr <= '0;
                bcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_word_loader
//   Drives one serial stream into two loaders (little-endian / 16-bit address
//   and big-endian / 4-bit address) and checks both against a byte-queue
//   model every cycle, plus literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_uart_word_loader;

    localparam int CPB    = 16;
    localparam int HALF   = CPB / 2;
    // Cycles from frame start to the edge that samples the stop bit, minus
    // one: 2 sync cycles + edge detect + half bit + 9 bits.
    localparam int CLR_AT = 2 + HALF + 9 * CPB;

    logic clk, rst_n, uart_rx, addr_clr;
    logic        le_valid, le_ferr, le_busy;
    logic [31:0] le_data;
    logic [15:0] le_addr;
    logic        be_valid, be_ferr, be_busy;
    logic [31:0] be_data;
    logic [3:0]  be_addr;

    int  checks = 0;
    int  errors = 0;
    bit  run_chk = 0;

    uart_word_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .ADDR_W(16), .ADDR_STEP(4),
                       .BIG_ENDIAN(0), .TIMEOUT_BITS(4)) dut_le (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .addr_clr(addr_clr),
        .word_valid(le_valid), .word_data(le_data), .word_addr(le_addr),
        .frame_err(le_ferr), .busy(le_busy));

    uart_word_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .ADDR_W(4), .ADDR_STEP(4),
                       .BIG_ENDIAN(1), .TIMEOUT_BITS(4)) dut_be (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .addr_clr(addr_clr),
        .word_valid(be_valid), .word_data(be_data), .word_addr(be_addr),
        .frame_err(be_ferr), .busy(be_busy));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    logic [7:0]  pend[$];
    logic [31:0] exp_le_data[$], exp_be_data[$];
    logic [15:0] exp_le_addr[$];
    logic [3:0]  exp_be_addr[$];
    logic [15:0] m_addr_le;
    logic [3:0]  m_addr_be;
    logic [31:0] last_le_data, last_be_data;
    logic [15:0] last_le_addr;
    logic [3:0]  last_be_addr;
    int          ferr_le, ferr_be;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_addr_le = '0; m_addr_be = '0;
        last_le_data = '0; last_le_addr = '0;
        last_be_data = '0; last_be_addr = '0;
        ferr_le = 0; ferr_be = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        pend.push_back(b);
        if (pend.size() == 4) begin
            exp_le_data.push_back({pend[3], pend[2], pend[1], pend[0]});
            exp_be_data.push_back({pend[0], pend[1], pend[2], pend[3]});
            exp_le_addr.push_back(m_addr_le);
            exp_be_addr.push_back(m_addr_be);
            m_addr_le = m_addr_le + 16'd4;
            m_addr_be = m_addr_be + 4'd4;
            pend.delete();
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (run_chk) begin
            if (le_valid) begin
                if (exp_le_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL le_valid: got pulse expected none");
                end else begin
                    last_le_data = exp_le_data.pop_front();
                    last_le_addr = exp_le_addr.pop_front();
                    chk("le_data", le_data, last_le_data);
                    chk("le_addr", le_addr, last_le_addr);
                end
            end else begin
                chk("le_data_hold", le_data, last_le_data);
                chk("le_addr_hold", le_addr, last_le_addr);
            end
            if (be_valid) begin
                if (exp_be_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL be_valid: got pulse expected none");
                end else begin
                    last_be_data = exp_be_data.pop_front();
                    last_be_addr = exp_be_addr.pop_front();
                    chk("be_data", be_data, last_be_data);
                    chk("be_addr", be_addr, last_be_addr);
                end
            end else begin
                chk("be_data_hold", be_data, last_be_data);
                chk("be_addr_hold", be_addr, last_be_addr);
            end
            if (le_ferr) begin
                checks++;
                if (ferr_le == 0) begin errors++; $display("FAIL le_frame_err: got pulse expected none"); end
                else ferr_le--;
            end
            if (be_ferr) begin
                checks++;
                if (ferr_be == 0) begin errors++; $display("FAIL be_frame_err: got pulse expected none"); end
                else ferr_be--;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Every task starts and ends 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        logic [9:0] fr;
        if (good) model_byte(b);
        else begin
            pend.delete();
            ferr_le++; ferr_be++;
        end
        fr = {good, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            idle(CPB);
        end
        if (!good) begin
            uart_rx = 1'b1;
            idle(CPB);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_le_valid"}, le_valid, 0);
        chk({tag, "_le_ferr"},  le_ferr,  0);
        chk({tag, "_le_busy"},  le_busy,  0);
        chk({tag, "_le_data"},  le_data,  0);
        chk({tag, "_le_addr"},  le_addr,  0);
        chk({tag, "_be_data"},  be_data,  0);
        chk({tag, "_be_addr"},  be_addr,  0);
        chk({tag, "_be_busy"},  be_busy,  0);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; uart_rx = 1'b1; addr_clr = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        run_chk = 1;
        #20;
        chk_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        idle(5);

        // 1: little/big-endian packing and address increment
        send_word(32'h3412AA55);
        chk("t1_le_data", le_data, 32'h3412AA55);
        chk("t1_le_addr", le_addr, 16'h0000);
        chk("t1_be_data", be_data, 32'h55AA1234);
        send_word(32'h3412AA55);
        chk("t1_le_addr2", le_addr, 16'h0004);
        idle(10);

        // 2: three more words, big-endian 4-bit address wraps on the fifth
        send_word(32'h67452301);
        send_word(32'hEFCDAB89);
        send_word(32'h0F1E2D3C);
        chk("t2_be_data", be_data, 32'h3C2D1E0F);
        chk("t2_be_addr_wrap", be_addr, 4'h0);
        chk("t2_le_addr", le_addr, 16'h0010);
        idle(10);

        // 3: bad stop bit discards the partial word
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        send_word(32'hA3A2A1A0);
        chk("t3_le_data", le_data, 32'hA3A2A1A0);
        chk("t3_le_addr", le_addr, 16'h0014);
        idle(10);

        // 4: short low glitch is a false start
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        chk("t4_busy_seen", le_busy, 1);
        n = 0;
        while ((le_busy || be_busy) && n < 20) begin idle(1); n++; end
        chk("t4_busy_cleared", le_busy | be_busy, 0);
        chk("t4_busy_bound", (n <= HALF + 3), 1);
        idle(10);

        // 5: partial word times out after 4 bit-times of idle
        send_byte(8'hEE, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(80);
        pend.delete();
        send_word(32'h04030201);
        chk("t5_le_data", le_data, 32'h04030201);
        chk("t5_le_addr", le_addr, 16'h0018);
        idle(10);

        // 6a: reset in the middle of a frame
        uart_rx = 1'b0;
        idle(40);
        rst_n = 1'b0;
        model_reset();
        uart_rx = 1'b1;
        idle(5);
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        idle(20);

        // 6b: addr_clr coincident with third word completion
        send_word(32'h13121110);
        chk("t6_w1_addr", le_addr, 16'h0000);
        send_word(32'h23222120);
        send_byte(8'h30, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        fork
            send_byte(8'h33, 1'b1);
            begin
                repeat (CLR_AT) @(posedge clk);
                #1 addr_clr = 1'b1;
                @(posedge clk);
                #1 addr_clr = 1'b0;
            end
        join
        m_addr_le = '0; m_addr_be = '0;
        chk("t6_w3_data", le_data, 32'h33323130);
        chk("t6_w3_addr", le_addr, 16'h0008);
        chk("t6_w3_be_addr", be_addr, 4'h8);
        send_word(32'h43424140);
        chk("t6_w4_addr", le_addr, 16'h0000);
        chk("t6_w4_be_addr", be_addr, 4'h0);
        idle(20);

        chk("le_words_outstanding", exp_le_data.size(), 0);
        chk("be_words_outstanding", exp_be_data.size(), 0);
        chk("le_ferr_outstanding", ferr_le, 0);
        chk("be_ferr_outstanding", ferr_be, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
